// File: rtl/dataflow_index_stream.sv
// dataflow_index_stream
//   Loop-index generator. Takes one (start, step, bound) config and emits the
//   signed sequence start, start+step, ... while index < bound, then a single
//   completion beat carrying the number of index beats emitted.
//
// Ports
//   clk, rst                 clock; asynchronous active-high reset
//   cfg_valid/cfg_ready      config handshake; start/step/bound sampled on fire
//   start_data               first index (signed)
//   step_data                increment (signed)
//   bound_data               exclusive upper bound (signed)
//   index_valid/index_ready  index stream handshake
//   index_data, index_last   current index, high on final beat of this config
//   done_valid/done_ready    completion handshake
//   done_data                trip count of the finished config
module dataflow_index_stream #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] start_data,
  input  logic [WIDTH-1:0] step_data,
  input  logic [WIDTH-1:0] bound_data,
  output logic             index_valid,
  input  logic             index_ready,
  output logic [WIDTH-1:0] index_data,
  output logic             index_last,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] done_data
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] idx;
  logic [WIDTH-1:0] step_r;
  logic [WIDTH-1:0] bound_r;
  logic [WIDTH-1:0] cnt;

  logic signed [WIDTH:0] nxt;
  logic                  nxt_ovf;
  logic                  nxt_reach;
  logic                  step_nonpos;
  logic                  last_cond;
  logic                  start_lt_bound;

  logic cfg_fire;
  logic index_fire;
  logic done_fire;

  // Next index is formed one bit wider so that signed overflow of the
  // WIDTH-bit range is visible as a disagreement of the top two bits.
  always_comb begin
    nxt         = $signed({idx[WIDTH-1], idx}) + $signed({step_r[WIDTH-1], step_r});
    nxt_ovf     = nxt[WIDTH] ^ nxt[WIDTH-1];
    nxt_reach   = nxt >= $signed({bound_r[WIDTH-1], bound_r});
    // A non-positive step could never reach the bound, so it ends after one beat.
    step_nonpos = step_r[WIDTH-1] | (step_r == '0);
    last_cond   = nxt_ovf | nxt_reach | step_nonpos;
  end

  assign start_lt_bound = $signed(start_data) < $signed(bound_data);

  // Outputs decode from registered state only; cfg_ready is also masked by
  // rst so nothing is offered while reset is held.
  assign cfg_ready   = (state == IDLE) & ~rst;
  assign index_valid = (state == RUN);
  assign index_last  = (state == RUN) & last_cond;
  assign index_data  = idx;
  assign done_valid  = (state == DONE);
  assign done_data   = cnt;

  assign cfg_fire   = cfg_valid & cfg_ready;
  assign index_fire = index_valid & index_ready;
  assign done_fire  = done_valid & done_ready;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (cfg_fire) state_nxt = start_lt_bound ? RUN : DONE;
      RUN:  if (index_fire && last_cond) state_nxt = DONE;
      DONE: if (done_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx     <= '0;
      step_r  <= '0;
      bound_r <= '0;
      cnt     <= '0;
    end else begin
      if (cfg_fire) begin
        step_r  <= step_data;
        bound_r <= bound_data;
        cnt     <= '0;
        if (start_lt_bound) idx <= start_data;
      end
      if (index_fire) begin
        cnt <= cnt + 1'b1;
        if (!last_cond) idx <= nxt[WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_dataflow_index_stream.sv
module tb_dataflow_index_stream;

  logic        clk;
  logic        rst;

  // 64-bit instance
  logic        cfg_valid, cfg_ready;
  logic [63:0] start_data, step_data, bound_data;
  logic        index_valid, index_ready, index_last;
  logic [63:0] index_data;
  logic        done_valid, done_ready;
  logic [63:0] done_data;

  // 8-bit instance for the overflow case
  logic        b_cfg_valid, b_cfg_ready;
  logic [7:0]  b_start_data, b_step_data, b_bound_data;
  logic        b_index_valid, b_index_ready, b_index_last;
  logic [7:0]  b_index_data;
  logic        b_done_valid, b_done_ready;
  logic [7:0]  b_done_data;

  int unsigned total;
  int unsigned passed;

  dataflow_index_stream #(.WIDTH(64)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .start_data(start_data), .step_data(step_data), .bound_data(bound_data),
    .index_valid(index_valid), .index_ready(index_ready),
    .index_data(index_data), .index_last(index_last),
    .done_valid(done_valid), .done_ready(done_ready), .done_data(done_data)
  );

  dataflow_index_stream #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .cfg_valid(b_cfg_valid), .cfg_ready(b_cfg_ready),
    .start_data(b_start_data), .step_data(b_step_data), .bound_data(b_bound_data),
    .index_valid(b_index_valid), .index_ready(b_index_ready),
    .index_data(b_index_data), .index_last(b_index_last),
    .done_valid(b_done_valid), .done_ready(b_done_ready), .done_data(b_done_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cfg(input logic [63:0] s, input logic [63:0] st, input logic [63:0] b);
    check("cfg_ready idle", 64'(cfg_ready), 64'd1);
    cfg_valid  = 1'b1;
    start_data = s;
    step_data  = st;
    bound_data = b;
    tick();
    cfg_valid  = 1'b0;
    // Later changes to the config inputs must be ignored.
    start_data = 64'hDEAD;
    step_data  = 64'h7;
    bound_data = 64'h1234;
    check("cfg_ready busy", 64'(cfg_ready), 64'd0);
  endtask

  task automatic exp_idx(input string tag, input logic [63:0] d, input logic l);
    check({tag, " valid"}, 64'(index_valid), 64'd1);
    check({tag, " data"}, index_data, d);
    check({tag, " last"}, 64'(index_last), 64'(l));
    tick();
  endtask

  task automatic exp_done(input string tag, input logic [63:0] n);
    check({tag, " done_valid"}, 64'(done_valid), 64'd1);
    check({tag, " done_data"}, done_data, n);
    check({tag, " no index"}, 64'(index_valid), 64'd0);
    tick();
    check({tag, " done drop"}, 64'(done_valid), 64'd0);
  endtask

  initial begin
    logic [63:0] exp_seq [4];
    int unsigned k;
    int unsigned cyc;

    total = 0;
    passed = 0;
    rst = 1'b1;
    cfg_valid = 1'b0; start_data = '0; step_data = '0; bound_data = '0;
    index_ready = 1'b1; done_ready = 1'b1;
    b_cfg_valid = 1'b0; b_start_data = '0; b_step_data = '0; b_bound_data = '0;
    b_index_ready = 1'b1; b_done_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst cfg_ready", 64'(cfg_ready), 64'd0);
    check("rst index_valid", 64'(index_valid), 64'd0);
    check("rst index_last", 64'(index_last), 64'd0);
    check("rst done_valid", 64'(done_valid), 64'd0);
    check("rst index_data", index_data, 64'd0);
    check("rst done_data", done_data, 64'd0);
    rst = 1'b0;
    tick();

    // Case 1: 0,1,2,3
    send_cfg(64'd0, 64'd1, 64'd4);
    exp_idx("c1 i0", 64'd0, 1'b0);
    exp_idx("c1 i1", 64'd1, 1'b0);
    exp_idx("c1 i2", 64'd2, 1'b0);
    exp_idx("c1 i3", 64'd3, 1'b1);
    exp_done("c1", 64'd4);

    // Case 2: 2,5,8
    send_cfg(64'd2, 64'd3, 64'd10);
    exp_idx("c2 i0", 64'd2, 1'b0);
    exp_idx("c2 i1", 64'd5, 1'b0);
    exp_idx("c2 i2", 64'd8, 1'b1);
    exp_done("c2", 64'd3);

    // Case 3: zero-trip, done in the cycle after cfg fire
    send_cfg(64'd5, 64'd1, 64'd5);
    exp_done("c3", 64'd0);

    // Case 4: index_ready pattern 1,0,0 repeating
    exp_seq[0] = 64'd0; exp_seq[1] = 64'd1; exp_seq[2] = 64'd2; exp_seq[3] = 64'd3;
    send_cfg(64'd0, 64'd1, 64'd4);
    k = 0;
    cyc = 0;
    while (k < 4 && cyc < 30) begin
      index_ready = (cyc % 3 == 0);
      check("c4 valid", 64'(index_valid), 64'd1);
      check("c4 data", index_data, exp_seq[k]);
      check("c4 last", 64'(index_last), 64'(k == 3));
      tick();
      if (index_ready) k++;
      cyc++;
    end
    check("c4 beats", 64'(k), 64'd4);
    index_ready = 1'b1;
    exp_done("c4", 64'd4);

    // Case 5: 8-bit overflow, then step=0
    check("w8 cfg_ready", 64'(b_cfg_ready), 64'd1);
    b_cfg_valid = 1'b1; b_start_data = 8'd120; b_step_data = 8'd5; b_bound_data = 8'd127;
    tick();
    b_cfg_valid = 1'b0;
    check("w8 i0 data", 64'(b_index_data), 64'd120);
    check("w8 i0 last", 64'(b_index_last), 64'd0);
    tick();
    check("w8 i1 valid", 64'(b_index_valid), 64'd1);
    check("w8 i1 data", 64'(b_index_data), 64'd125);
    check("w8 i1 last", 64'(b_index_last), 64'd1);
    tick();
    check("w8 done_valid", 64'(b_done_valid), 64'd1);
    check("w8 done_data", 64'(b_done_data), 64'd2);
    tick();
    b_cfg_valid = 1'b1; b_start_data = 8'd0; b_step_data = 8'd0; b_bound_data = 8'd9;
    tick();
    b_cfg_valid = 1'b0;
    check("w8 s0 valid", 64'(b_index_valid), 64'd1);
    check("w8 s0 data", 64'(b_index_data), 64'd0);
    check("w8 s0 last", 64'(b_index_last), 64'd1);
    tick();
    check("w8 s0 done_valid", 64'(b_done_valid), 64'd1);
    check("w8 s0 done_data", 64'(b_done_data), 64'd1);
    tick();

    // Case 6: reset during RUN after two beats
    send_cfg(64'd0, 64'd1, 64'd4);
    exp_idx("c6 i0", 64'd0, 1'b0);
    exp_idx("c6 i1", 64'd1, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("c6 rst index_valid", 64'(index_valid), 64'd0);
    check("c6 rst cfg_ready", 64'(cfg_ready), 64'd0);
    check("c6 rst done_valid", 64'(done_valid), 64'd0);
    check("c6 rst index_data", index_data, 64'd0);
    tick();
    rst = 1'b0;
    tick();
    check("c6 post index_valid", 64'(index_valid), 64'd0);
    check("c6 post done_valid", 64'(done_valid), 64'd0);
    send_cfg(-64'sd3, 64'd2, 64'd0);
    exp_idx("c6 n0", -64'sd3, 1'b0);
    exp_idx("c6 n1", -64'sd1, 1'b1);
    exp_done("c6", 64'd2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
